mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-to-one arbiter sharing a single-port unified memory between the core's instruction-fetch port (imem) and load/store port (dmem). It sits between `riscv_core` and the memory model or SoC bus. It serialises valid/ready transactions, latches the granted request, and routes the ready strobe and read data back to the winner. An optional watchdog aborts transactions the memory never acknowledges.

## Interface
Parameters:
- `ADDR_W`, default `RISCV_ADDR_WIDTH`: address width.
- `DATA_W`, default `RISCV_WORD_WIDTH`: data width.
- `FIXED_PRIO`, default 0: 0 = round-robin; 1 = dmem always wins.
- `TIMEOUT`, default 0: cycles to wait for `mem_ready_i` before aborting; 0 disables the watchdog.

Ports (reset is synchronous and active-high):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_valid_i`  in  1  fetch request.
- `imem_ready_o`  out  1  fetch completion strobe.
- `imem_addr_i`  in  ADDR_W
- `imem_wdata_i`  in  DATA_W
- `imem_we_i`  in  4  byte write enables.
- `imem_rdata_o`  out  DATA_W
- `dmem_valid_i`, `dmem_ready_o`, `dmem_addr_i`, `dmem_wdata_i`, `dmem_we_i`, `dmem_rdata_o`: same widths and meanings as the imem port.
- `mem_valid_o`  out  1  downstream request, registered.
- `mem_ready_i`  in  1  downstream completion.
- `mem_addr_o`  out  ADDR_W  registered.
- `mem_wdata_o`  out  DATA_W  registered.
- `mem_we_o`  out  4  registered.
- `mem_rdata_i`  in  DATA_W
- `err_o`  out  1  one-cycle pulse when a transaction times out.
- `err_port_o`  out  1  port that timed out: 0 = imem, 1 = dmem.

## Operation
- **States:** IDLE and BUSY, held in `arb_state_t`.
- **IDLE:** if any `*_valid_i` is high, pick a winner.
  - Only one port requesting: that port wins.
  - Both requesting, `FIXED_PRIO=1`: dmem wins.
  - Both requesting, `FIXED_PRIO=0`: the port not recorded in `last_grant` wins.
  - On a pick, latch the winner's addr/wdata/we into `mem_*_o`, set `mem_valid_o`, set `grant`, set `last_grant` = winner, clear the timeout counter, and go to BUSY.
- **BUSY with `mem_ready_i` high:**
  - Assert the winner's `*_ready_o` combinationally in the same cycle.
  - Drive the winner's `*_rdata_o` = `mem_rdata_i`.
  - Next edge: clear `mem_valid_o` and return to IDLE.
- **BUSY without ready:** hold all `mem_*_o` stable and increment the timeout counter.
- **Timeout:** with `TIMEOUT>0`, when the counter reaches `TIMEOUT-1` and `mem_ready_i` is still low:
  - Next edge: pulse `err_o`, set `err_port_o` = `grant`, clear `mem_valid_o`, go to IDLE.
  - The requester receives no `ready_o`; recovery is a system concern.
- **Counter width:** `$clog2(TIMEOUT+1)` bits, saturating, never wraps.
- **Non-granted port:** `ready_o`=0 and `rdata_o`=0 at all times.
- **Protocol:** masters hold valid and request fields until their ready. If a master drops valid mid-transaction, the arbiter still completes the transaction downstream and asserts the now-unused ready.
- **Arbitration scope:** only IDLE arbitrates. A request arriving during BUSY waits and has no effect on the current transaction.

## Timing
- **Reset values:** `mem_valid_o`=0, `mem_addr_o`/`mem_wdata_o`/`mem_we_o`=0, `err_o`=0, `err_port_o`=0, state IDLE, `last_grant`=dmem (so imem wins the first tie), both `ready_o`=0.
- **Reset mid-transaction:** `mem_valid_o` drops on the reset edge; any `mem_ready_i` in the reset cycle is ignored.
- **Request latency:** request seen in IDLE at cycle N → `mem_valid_o` high at N+1.
- **Completion:** `mem_ready_i` at cycle M ≥ N+1 → winner's `ready_o` in cycle M (zero-cycle return).
- **Back-to-back:** next request can be seen in IDLE at M+1, earliest `mem_valid_o` at M+2. Minimum 2 cycles per transaction; the bubble is intended.
- **Watchdog timing:** with `TIMEOUT`=T, `err_o` pulses exactly T cycles after `mem_valid_o` first rises, if no ready arrived.
- **Ready and timeout in the same cycle:** ready wins; no error.

## Structure
- Shared package `riscv_defines.sv` gets:
  - `arb_state_t` enum {ARB_IDLE, ARB_BUSY}.
  - `localparam` values `ARB_PORT_IMEM`=0 and `ARB_PORT_DMEM`=1.
- One sub-module, `arb_pick`: combinational winner selection from two valids, `last_grant` and `FIXED_PRIO`. Kept separate so it can be reused for a future third requester (debug port).
- Everything else (state register, latches, watchdog, return mux) stays in `mem_arbiter`.

## Test plan
- **imem only:** `imem_valid_i`=1, addr 0x100, memory ready 2 cycles later with 0xDEADBEEF → `mem_valid_o` rises the cycle after the request, `mem_addr_o`=0x100, `imem_ready_o` high for 1 cycle with `imem_rdata_o`=0xDEADBEEF, `dmem_ready_o`=0 throughout.
- **Both request from reset, `FIXED_PRIO`=0:** both held valid → grant order imem, dmem, imem, dmem over 4 transactions, with ≥1 idle cycle of `mem_valid_o` between them.
- **Both request, `FIXED_PRIO`=1:** dmem store (we=4'b1111, wdata 0x12345678) then imem → dmem served first, `mem_we_o`=4'hF, `mem_wdata_o`=0x12345678; imem served after.
- **Watchdog, `TIMEOUT`=8:** `mem_ready_i` never asserted → `err_o` pulses exactly 8 cycles after `mem_valid_o` rises, `err_port_o` matches the grant, `mem_valid_o` falls, then a pending request is served normally.
- **Reset mid-transaction:** `rst` asserted during BUSY, then released → all outputs at reset values the next cycle; the first post-reset tie goes to imem.
- **Stability check:** memory withholds ready for 5 cycles while the losing master toggles its addr → `mem_addr_o`/`mem_wdata_o`/`mem_we_o` stay unchanged until ready.

Source files
------------

// File: rtl/riscv_defines.sv
// riscv_defines: shared core widths plus memory-arbiter state and port encodings.
package riscv_defines;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam logic ARB_PORT_IMEM = 1'b0;
    localparam logic ARB_PORT_DMEM = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational two-way winner selection, fixed dmem priority or round-robin.
module arb_pick
    import riscv_defines::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic imem_valid_i,
    input  logic dmem_valid_i,
    input  logic last_grant_i,
    output logic grant_o
);

    // A lone requester always wins; ties go to dmem or to whoever did not win last.
    assign grant_o = (imem_valid_i ^ dmem_valid_i) ? dmem_valid_i :
                     (FIXED_PRIO != 0) ? ARB_PORT_DMEM : ~last_grant_i;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store ports,
// with registered request latching, zero-cycle ready return and optional watchdog.
module mem_arbiter
    import riscv_defines::*;
#(
    parameter int ADDR_W     = RISCV_ADDR_WIDTH,
    parameter int DATA_W     = RISCV_WORD_WIDTH,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_valid_i,
    output logic              imem_ready_o,
    input  logic [ADDR_W-1:0] imem_addr_i,
    input  logic [DATA_W-1:0] imem_wdata_i,
    input  logic [3:0]        imem_we_i,
    output logic [DATA_W-1:0] imem_rdata_o,
    input  logic              dmem_valid_i,
    output logic              dmem_ready_o,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_wdata_i,
    input  logic [3:0]        dmem_we_i,
    output logic [DATA_W-1:0] dmem_rdata_o,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              err_o,
    output logic              err_port_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        we_q, we_d;
    logic              err_q, err_d;
    logic              err_port_q, err_port_d;
    logic              pick;
    logic              done;
    logic              expire;

    arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .imem_valid_i(imem_valid_i),
        .dmem_valid_i(dmem_valid_i),
        .last_grant_i(last_grant_q),
        .grant_o     (pick)
    );

    // Completion seen during the reset cycle is discarded.
    assign done   = (state_q == ARB_BUSY) && mem_ready_i && !rst;
    assign expire = (TIMEOUT > 0) && (state_q == ARB_BUSY) && !mem_ready_i && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        err_d        = 1'b0;
        err_port_d   = err_port_q;
        if (state_q == ARB_IDLE) begin
            if (imem_valid_i || dmem_valid_i) begin
                state_d      = ARB_BUSY;
                grant_d      = pick;
                last_grant_d = pick;
                cnt_d        = '0;
                valid_d      = 1'b1;
                addr_d       = pick ? dmem_addr_i : imem_addr_i;
                wdata_d      = pick ? dmem_wdata_i : imem_wdata_i;
                we_d         = pick ? dmem_we_i : imem_we_i;
            end
        end else if (mem_ready_i) begin
            state_d = ARB_IDLE;
            valid_d = 1'b0;
        end else if (expire) begin
            state_d    = ARB_IDLE;
            valid_d    = 1'b0;
            err_d      = 1'b1;
            err_port_d = grant_q;
        end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= ARB_PORT_IMEM;
            last_grant_q <= ARB_PORT_DMEM;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= '0;
            err_q        <= 1'b0;
            err_port_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            err_q        <= err_d;
            err_port_q   <= err_port_d;
        end
    end

    assign imem_ready_o = done && (grant_q == ARB_PORT_IMEM);
    assign dmem_ready_o = done && (grant_q == ARB_PORT_DMEM);
    assign imem_rdata_o = imem_ready_o ? mem_rdata_i : '0;
    assign dmem_rdata_o = dmem_ready_o ? mem_rdata_i : '0;
    assign mem_valid_o  = valid_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_we_o     = we_q;
    assign err_o        = err_q;
    assign err_port_o   = err_port_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench; instance 0 is round-robin with an 8-cycle watchdog,
// instance 1 is fixed dmem priority without watchdog.
module tb_mem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        logic [31:0] rdata;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv[2], dv[2], ir[2], dr[2], mv[2], mr[2], err[2], errp[2];
    logic [31:0] ia[2], iw[2], da[2], dw[2], ird[2], drd[2], ma[2], mw[2], mrd[2];
    logic [3:0]  iwe[2], dwe[2], mwe[2];
    ent_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.FIXED_PRIO(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .rst(rst),
        .imem_valid_i(iv[0]), .imem_ready_o(ir[0]), .imem_addr_i(ia[0]),
        .imem_wdata_i(iw[0]), .imem_we_i(iwe[0]), .imem_rdata_o(ird[0]),
        .dmem_valid_i(dv[0]), .dmem_ready_o(dr[0]), .dmem_addr_i(da[0]),
        .dmem_wdata_i(dw[0]), .dmem_we_i(dwe[0]), .dmem_rdata_o(drd[0]),
        .mem_valid_o(mv[0]), .mem_ready_i(mr[0]), .mem_addr_o(ma[0]),
        .mem_wdata_o(mw[0]), .mem_we_o(mwe[0]), .mem_rdata_i(mrd[0]),
        .err_o(err[0]), .err_port_o(errp[0])
    );

    mem_arbiter #(.FIXED_PRIO(1), .TIMEOUT(0)) dut1 (
        .clk(clk), .rst(rst),
        .imem_valid_i(iv[1]), .imem_ready_o(ir[1]), .imem_addr_i(ia[1]),
        .imem_wdata_i(iw[1]), .imem_we_i(iwe[1]), .imem_rdata_o(ird[1]),
        .dmem_valid_i(dv[1]), .dmem_ready_o(dr[1]), .dmem_addr_i(da[1]),
        .dmem_wdata_i(dw[1]), .dmem_we_i(dwe[1]), .dmem_rdata_o(drd[1]),
        .mem_valid_o(mv[1]), .mem_ready_i(mr[1]), .mem_addr_o(ma[1]),
        .mem_wdata_o(mw[1]), .mem_we_o(mwe[1]), .mem_rdata_i(mrd[1]),
        .err_o(err[1]), .err_port_o(errp[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic p, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] we, input logic [31:0] r);
        exp_q.push_back('{p, a, w, we, r});
    endtask

    // Memory side: waits for a request, checks it against the scoreboard head,
    // withholds ready for lat cycles while the losing master wiggles its address.
    task automatic serve(input int d, input int lat, input bit keep);
        ent_t        e;
        logic [31:0] sv;
        for (int i = 0; i < 60 && !mv[d]; i++) @(negedge clk);
        chk("req_valid", {31'b0, mv[d]}, 1);
        e = exp_q.pop_front();
        chk("addr", ma[d], e.addr);
        chk("wdata", mw[d], e.wdata);
        chk("we", {28'b0, mwe[d]}, {28'b0, e.we});
        sv = e.port ? ia[d] : da[d];
        for (int i = 0; i < lat; i++) begin
            if (e.port) ia[d] = ia[d] ^ 32'h0000_0ff0;
            else        da[d] = da[d] ^ 32'h0000_0ff0;
            @(negedge clk);
            chk("hold_addr", ma[d], e.addr);
            chk("hold_wdata", mw[d], e.wdata);
            chk("hold_we", {28'b0, mwe[d]}, {28'b0, e.we});
            chk("early_rdy", {31'b0, ir[d] | dr[d]}, 0);
        end
        if (e.port) ia[d] = sv;
        else        da[d] = sv;
        mr[d]  = 1'b1;
        mrd[d] = e.rdata;
        #1;
        chk("win_rdy", {31'b0, e.port ? dr[d] : ir[d]}, 1);
        chk("win_rdata", e.port ? drd[d] : ird[d], e.rdata);
        chk("lose_rdy", {31'b0, e.port ? ir[d] : dr[d]}, 0);
        chk("lose_rdata", e.port ? ird[d] : drd[d], 0);
        @(negedge clk);
        mr[d]  = 1'b0;
        mrd[d] = '0;
        if (!keep) begin
            if (e.port) dv[d] = 1'b0;
            else        iv[d] = 1'b0;
        end
        #1;
        chk("bubble", {31'b0, mv[d]}, 0);
        chk("rdy_pulse", {31'b0, ir[d] | dr[d]}, 0);
    endtask

    task automatic wd(input int d, input logic p);
        for (int i = 0; i < 60 && !mv[d]; i++) @(negedge clk);
        chk("wd_valid", {31'b0, mv[d]}, 1);
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk("wd_err_early", {31'b0, err[d]}, 0);
            chk("wd_hold", {31'b0, mv[d]}, 1);
        end
        @(negedge clk);
        chk("wd_err", {31'b0, err[d]}, 1);
        chk("wd_port", {31'b0, errp[d]}, {31'b0, p});
        chk("wd_drop", {31'b0, mv[d]}, 0);
        chk("wd_no_rdy", {31'b0, ir[d] | dr[d]}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hung want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 0; dv[d] = 0; mr[d] = 0;
            ia[d] = 0; iw[d] = 0; da[d] = 0; dw[d] = 0; mrd[d] = 0;
            iwe[d] = 0; dwe[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_valid", {31'b0, mv[d]}, 0);
            chk("rst_addr", ma[d], 0);
            chk("rst_err", {31'b0, err[d] | errp[d]}, 0);
            chk("rst_rdy", {31'b0, ir[d] | dr[d]}, 0);
        end
        rst = 1'b0;

        // Single fetch, ready two cycles after the request lands.
        iv[0] = 1; ia[0] = 32'h100;
        push(0, 32'h100, 0, 0, 32'hdeadbeef);
        #1 chk("pre_valid", {31'b0, mv[0]}, 0);
        @(negedge clk);
        chk("latency", {31'b0, mv[0]}, 1);
        serve(0, 2, 0);

        // Round-robin from reset with both masters holding valid.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        iv[0] = 1; ia[0] = 32'h200; dv[0] = 1; da[0] = 32'h300;
        push(0, 32'h200, 0, 0, 32'h1111_1111);
        push(1, 32'h300, 0, 0, 32'h2222_2222);
        push(0, 32'h200, 0, 0, 32'h3333_3333);
        push(1, 32'h300, 0, 0, 32'h4444_4444);
        repeat (4) serve(0, 1, 1);
        iv[0] = 0; dv[0] = 0;

        // Fixed priority: dmem store beats imem fetch.
        iv[1] = 1; ia[1] = 32'h500;
        dv[1] = 1; da[1] = 32'h400; dw[1] = 32'h12345678; dwe[1] = 4'hf;
        push(1, 32'h400, 32'h12345678, 4'hf, 32'h0);
        push(0, 32'h500, 0, 0, 32'h5555_aaaa);
        serve(1, 1, 0);
        serve(1, 1, 0);

        // Held request: loser toggles its address while memory stalls.
        @(negedge clk);
        iv[0] = 1; ia[0] = 32'h900; iw[0] = 32'h0; iwe[0] = 4'h0;
        dv[0] = 1; da[0] = 32'ha00; dw[0] = 32'hfeed_0001; dwe[0] = 4'h1;
        push(0, 32'h900, 0, 0, 32'h9999_0000);
        push(1, 32'ha00, 32'hfeed_0001, 4'h1, 32'h0);
        serve(0, 5, 0);
        serve(0, 1, 0);

        // Watchdog: imem times out, then the pending dmem times out, then is served.
        @(negedge clk);
        iv[0] = 1; ia[0] = 32'h600; dwe[0] = 4'h0; dw[0] = 0;
        @(negedge clk);
        dv[0] = 1; da[0] = 32'h700;
        wd(0, 0);
        iv[0] = 0;
        wd(0, 1);
        push(1, 32'h700, 0, 0, 32'h7777_0000);
        serve(0, 1, 0);

        // Reset during BUSY with a ready offered in the reset cycle.
        @(negedge clk);
        iv[0] = 1; ia[0] = 32'h800; iw[0] = 32'hcafe_f00d; iwe[0] = 4'h3;
        for (int i = 0; i < 60 && !mv[0]; i++) @(negedge clk);
        chk("mid_valid", {31'b0, mv[0]}, 1);
        mr[0] = 1; mrd[0] = 32'h1234_0000; rst = 1'b1;
        #1 chk("rst_cycle_rdy", {31'b0, ir[0]}, 0);
        @(negedge clk);
        rst = 1'b0; mr[0] = 0; mrd[0] = 0;
        chk("mid_rst_valid", {31'b0, mv[0]}, 0);
        chk("mid_rst_addr", ma[0], 0);
        chk("mid_rst_wdata", mw[0], 0);
        chk("mid_rst_we", {28'b0, mwe[0]}, 0);
        chk("mid_rst_err", {31'b0, err[0] | errp[0]}, 0);
        dv[0] = 1; da[0] = 32'hb00;
        push(0, 32'h800, 32'hcafe_f00d, 4'h3, 32'h0bad_0001);
        push(1, 32'hb00, 0, 0, 32'h0bad_0002);
        serve(0, 0, 0);
        serve(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
